mult_iter: RTL and testbench
============================

Name: mult_iter

Overview:
- Parametrised, iterative shift-add integer multiplier for the FP8 MAC datapath.
- Successor to the fixed 4x4 combinational mantissa multiplier: operand width is generic and a per-transaction signed mode is added.
- Computes one partial product per clock, trading latency for area.
- Uses valid/ready handshakes on input and output so it can sit between the exponent/align stage and the accumulator with backpressure.

Parameters:
- WIDTH, 4, operand width in bits (legal 2..16); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b/in_signed valid.
- in_ready  output  1  block can accept operands.
- in_signed  input  1  1: a, b are two's complement; 0: unsigned.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- product  output  2*WIDTH  result (two's complement when the accepted in_signed was 1).
- busy  output  1  high in BUSY state.

Behaviour:
- Reset values, applied asynchronously while rst=1:
  - state=IDLE; out_valid=0; product=0; busy=0.
  - in_ready=1 (combinational from IDLE).
  - Internal registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge (acceptance edge T0):
    - Capture mcand = |a| zero-extended to 2*WIDTH, mplier = |b|, neg = in_signed&&(a[MSB]^b[MSB]), acc=0, cnt=0.
    - Go to BUSY.
  - When in_signed=0, magnitudes are the raw operands and neg=0.
  - Magnitude of the most-negative value (e.g. 4'b1000) is 2^(WIDTH-1), which fits WIDTH unsigned bits; no overflow.
- BUSY:
  - in_ready=0; busy=1.
  - Each edge:
    - if mplier[0], acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
  - At the edge where cnt reaches WIDTH (edge T0+WIDTH):
    - product <= neg ? -acc : acc (2*WIDTH-bit two's complement);
    - out_valid <= 1; go to DONE.
  - Fixed latency: out_valid rises exactly WIDTH cycles after the acceptance edge. No early termination on zero operands.
- DONE:
  - in_ready=0; out_valid=1; product held stable.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE.
  - product keeps its last value until the next completion; it is not cleared.
- in_ready is asserted only in IDLE. in_valid outside IDLE is ignored, with no capture and no side effect.
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH iterations, DONE handshake cycle).
- Operands are sampled only at the acceptance edge; changes to a/b/in_signed afterwards do not affect the result.
- Arithmetic:
  - Unsigned range: (2^WIDTH-1)^2 fits 2*WIDTH bits.
  - Signed range: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), representable as a positive 2*WIDTH-bit value.
  - Zero result with neg=1 yields 0, not negative zero.
- Reset asserted in BUSY or DONE:
  - Operation aborted immediately; no out_valid pulse; state returns to IDLE.
  - First acceptance is possible at the first clock edge after rst deasserts.

Test Plan:
- WIDTH=4, unsigned, a=15, b=15 accepted at edge T0 -> out_valid rises at T0+4 with product=0xE1; busy=1 during those 4 cycles; in_ready=0 until the handshake completes.
- WIDTH=4, signed:
  - a=4'h8 (-8), b=4'h8 -> product=0x40.
  - a=4'hD (-3), b=5 -> product=0xF1 (-15).
  - a=4'h7, b=4'hF (-1) -> product=0xF9.
- Zero operands:
  - unsigned 0*13 -> 0x00.
  - signed a=0, b=4'hF -> 0x00 (no negative zero).
  - Latency still exactly 4 cycles.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, product constant.
  - in_valid pulses with new operands in that window are ignored.
  - Raise out_ready -> IDLE next cycle, in_ready=1; the next operation returns its own correct result.
- Reset mid-operation:
  - Assert rst two cycles into BUSY -> out_valid=0, product=0, busy=0 and in_ready=1 immediately.
  - After release, 3*5 unsigned -> 0x0F.
- WIDTH=8, 1000 random signed/unsigned ops with random out_ready stalls against a reference model, including:
  - 255*255 unsigned -> 0xFE01.
  - -128*-128 signed -> 0x4000.
  - -128*127 signed -> 0xC080.

Source files
------------

// File: rtl/mult_iter.sv
// Iterative shift-add integer multiplier with valid/ready handshakes.
// One partial product per clock; signed mode works on magnitudes and fixes the sign at the end.
module mult_iter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int PW = 2*WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    mcand, acc, acc_nxt;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic             neg, last;

  // Most-negative operand negates to itself, which reads correctly as an unsigned magnitude.
  assign a_mag   = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (in_signed && b[WIDTH-1]) ? -b : b;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= PW'(a_mag);
          mplier <= b_mag;
          neg    <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            product   <= neg ? -acc_nxt : acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_iter.sv
// Self-checking bench for mult_iter: directed WIDTH=4 scenarios and a randomized WIDTH=8 run
// against a scoreboard of expected products.
module tb_mult_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid4, in_ready4, in_signed4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] product4;

  logic       in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
  logic [7:0] a8, b8;
  logic [15:0] product8;

  int checks = 0;
  int errors = 0;
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  mult_iter #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_signed(in_signed4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
  );

  mult_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input bit s);
    int av, bv;
    av = s ? int'($signed(a)) : int'(a);
    bv = s ? int'($signed(b)) : int'(b);
    return 16'(av * bv);
  endfunction

  // Caller is in IDLE, 1 time unit after a rising edge.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s,
                     input logic [7:0] exp, input int hold, input string name);
    logic [7:0] e;
    in_valid4 = 1'b1; a4 = a; b4 = b; in_signed4 = s;
    out_ready4 = (hold == 0);
    q4.push_back(exp);
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = ~a; b4 = ~b; in_signed4 = ~s;
    checks++;
    if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin
      errors++; $display("FAIL %s accept: busy=%b in_ready=%b, want busy=1 in_ready=0", name, busy4, in_ready4);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        checks++;
        if (out_valid4 !== 1'b0 || busy4 !== 1'b1) begin
          errors++; $display("FAIL %s iter%0d: out_valid=%b busy=%b, want 0/1", name, k, out_valid4, busy4);
        end
      end
    end
    checks++;
    if (out_valid4 !== 1'b1 || busy4 !== 1'b0 || in_ready4 !== 1'b0) begin
      errors++; $display("FAIL %s latency: out_valid=%b busy=%b in_ready=%b, want 1/0/0", name, out_valid4, busy4, in_ready4);
    end
    e = q4.pop_front();
    checks++;
    if (product4 !== e) begin
      errors++; $display("FAIL %s product: got %h want %h", name, product4, e);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); in_signed4 = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid4 !== 1'b1 || product4 !== e || in_ready4 !== 1'b0) begin
        errors++; $display("FAIL %s stall%0d: out_valid=%b product=%h in_ready=%b, want 1/%h/0", name, h, out_valid4, product4, in_ready4, e);
      end
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL %s handshake: out_valid=%b in_ready=%b, want 0/1", name, out_valid4, in_ready4);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || product4 !== 8'h00 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL reset4: out_valid=%b product=%h busy=%b in_ready=%b", out_valid4, product4, busy4, in_ready4);
    end
    checks++;
    if (out_valid8 !== 1'b0 || product8 !== 16'h0 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL reset8: out_valid=%b product=%h busy=%b in_ready=%b", out_valid8, product8, busy8, in_ready8);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed4();
    op4(4'hF, 4'hF, 1'b0, 8'hE1, 0, "u15x15");
    op4(4'h8, 4'h8, 1'b1, 8'h40, 0, "s-8x-8");
    op4(4'hD, 4'h5, 1'b1, 8'hF1, 0, "s-3x5");
    op4(4'h7, 4'hF, 1'b1, 8'hF9, 0, "s7x-1");
    op4(4'h0, 4'hD, 1'b0, 8'h00, 0, "u0x13");
    op4(4'h0, 4'hF, 1'b1, 8'h00, 0, "s0x-1");
  endtask

  task automatic test_backpressure();
    op4(4'h6, 4'h7, 1'b0, 8'h2A, 10, "bp6x7");
    op4(4'h2, 4'h3, 1'b0, 8'h06, 0, "after_bp");
  endtask

  task automatic test_reset_mid();
    in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h9; in_signed4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid4 !== 1'b0 || product4 !== 8'h00 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++; $display("FAIL reset_mid: out_valid=%b product=%h busy=%b in_ready=%b, want 0/00/0/1", out_valid4, product4, busy4, in_ready4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    op4(4'h3, 4'h5, 1'b0, 8'h0F, 0, "after_rst");
  endtask

  task automatic test_random8(input int n);
    fork
      begin : driver
        logic [7:0] ra, rb;
        bit rs;
        for (int i = 0; i < n; i++) begin
          int w = 0;
          while (!in_ready8 && w < 200) begin @(posedge clk); #1; w++; end
          if (w >= 200) begin
            checks++; errors++;
            $display("FAIL rand8 driver timeout at op %0d: in_ready=%b want 1", i, in_ready8);
            break;
          end
          ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
          case (i)
            0: begin ra = 8'hFF; rb = 8'hFF; rs = 1'b0; q8.push_back(16'hFE01); end
            1: begin ra = 8'h80; rb = 8'h80; rs = 1'b1; q8.push_back(16'h4000); end
            2: begin ra = 8'h80; rb = 8'h7F; rs = 1'b1; q8.push_back(16'hC080); end
            default: q8.push_back(model8(ra, rb, rs));
          endcase
          in_valid8 = 1'b1; a8 = ra; b8 = rb; in_signed8 = rs;
          @(posedge clk); #1;
          in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        end
      end
      begin : monitor
        int got = 0;
        logic [15:0] e;
        for (int cyc = 0; cyc < 40000 && got < n; cyc++) begin
          @(posedge clk); #1;
          out_ready8 = ($urandom_range(0, 2) != 0);
          if (out_valid8 && out_ready8) begin
            checks++;
            if (q8.size() == 0) begin
              errors++; $display("FAIL rand8 unexpected output %h", product8);
            end else begin
              e = q8.pop_front();
              if (product8 !== e) begin
                errors++; $display("FAIL rand8 op %0d: got %h want %h", got, product8, e);
              end
            end
            got++;
          end
        end
        if (got < n) begin
          checks++; errors++;
          $display("FAIL rand8 timeout: got %0d results want %0d", got, n);
        end
      end
    join
  endtask

  initial begin
    in_valid4 = 0; in_signed4 = 0; a4 = 0; b4 = 0; out_ready4 = 1;
    in_valid8 = 0; in_signed8 = 0; a8 = 0; b8 = 0; out_ready8 = 1;
    test_reset();
    test_directed4();
    test_backpressure();
    test_reset_mid();
    test_random8(1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
